// File: rtl/reg_file_sb.sv
// Multi-port register file with WB write-through bypass and a per-register
// pending-write scoreboard. Define ZERO_REG_EN to hardwire register 0 to zero.

module reg_file_sb_rd_port #(
  parameter int DW     = 16,
  parameter int AW     = 3,
  parameter int PW     = 2,
  parameter int BYPASS = 1
) (
  input  logic [(1<<AW)-1:0][DW-1:0] regs,
  input  logic [(1<<AW)-1:0][PW-1:0] cnt,
  input  logic [AW-1:0]              addr,
  input  logic                       use_op,
  input  logic                       wr_eff,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  output logic [DW-1:0]              data,
  output logic                       busy,
  output logic                       hazard
);
  logic fwd;

  assign fwd    = (BYPASS != 0) && wr_eff && (wr_addr == addr);
  assign data   = fwd ? wr_data : regs[addr];
  // The single outstanding write landing this cycle resolves the hazard.
  assign busy   = (cnt[addr] != '0) && !(fwd && (cnt[addr] == PW'(1)));
  assign hazard = use_op && busy;
endmodule

module reg_file_sb #(
  parameter int DW     = 16,
  parameter int AW     = 3,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int PW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NRD-1:0]    rd_use,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_ack,
  output logic              stall,
  output logic [AW+PW-1:0]  pend_cnt
);
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + PW;
  localparam logic [PW-1:0] CMAX = '1;
`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DEPTH-1:0][DW-1:0] regs;
  logic [DEPTH-1:0][PW-1:0] cnt;
  logic [NRD-1:0]           hazard;
  logic                     wr_eff, iss_cnt, iss_sat, dec_any;

  assign wr_eff  = wr_en && !(ZERO_REG && (wr_addr == '0));
  assign iss_sat = iss_en && (cnt[iss_addr] == CMAX);
  assign stall   = (|hazard) || iss_sat;
  assign iss_ack = iss_en && !stall;
  // An acked issue to the zero register is never counted.
  assign iss_cnt = iss_ack && !(ZERO_REG && (iss_addr == '0));
  assign dec_any = wr_en && (cnt[wr_addr] != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      reg_file_sb_rd_port #(.DW(DW), .AW(AW), .PW(PW), .BYPASS(BYPASS)) u_rd (
        .regs    (regs),
        .cnt     (cnt),
        .addr    (rd_addr[gi*AW +: AW]),
        .use_op  (rd_use[gi]),
        .wr_eff  (wr_eff),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (rd_data[gi*DW +: DW]),
        .busy    (rd_busy[gi]),
        .hazard  (hazard[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      regs     <= '0;
      cnt      <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_eff) regs[wr_addr] <= wr_data;
      for (int r = 0; r < DEPTH; r++) begin
        if (iss_cnt && (iss_addr == AW'(r)) && !(dec_any && (wr_addr == AW'(r))))
          cnt[r] <= cnt[r] + PW'(1);
        else if (dec_any && (wr_addr == AW'(r)) && !(iss_cnt && (iss_addr == AW'(r))))
          cnt[r] <= cnt[r] - PW'(1);
      end
      pend_cnt <= pend_cnt + CW'(iss_cnt) - CW'(dec_any);
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed checks of reg_file_sb against an array-based model.

module tb_reg_file_sb;
  localparam int DW = 16, AW = 3, NRD = 2, BYPASS = 1, PW = 2;
  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (1 << PW) - 1;
`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic              clk = 0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD-1:0]    rd_use;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              iss_ack, stall;
  logic [AW+PW-1:0]  pend_cnt;

  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] mregs [DEPTH];
  int            mcnt  [DEPTH];

  reg_file_sb #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(BYPASS), .PW(PW)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ack(iss_ack), .stall(stall),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit fwd(input int a);
    return BYPASS != 0 && wr_en && int'(wr_addr) == a && !(ZR && a == 0);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int a);
    if (fwd(a)) return wr_data;
    return (ZR && a == 0) ? '0 : mregs[a];
  endfunction

  function automatic bit exp_busy(input int a);
    return mcnt[a] != 0 && !(fwd(a) && mcnt[a] == 1);
  endfunction

  // Compare every output against the model, then advance one clock.
  task automatic cyc(input string tag);
    bit est, eack, dec;
    int sum;
    @(negedge clk);
    est = iss_en && mcnt[iss_addr] == CMAX;
    for (int i = 0; i < NRD; i++) begin
      int a = int'(rd_addr[i*AW +: AW]);
      chk($sformatf("%s.data%0d", tag, i), 32'(rd_data[i*DW +: DW]), 32'(exp_data(a)));
      chk($sformatf("%s.busy%0d", tag, i), 32'(rd_busy[i]), 32'(exp_busy(a)));
      if (rd_use[i] && exp_busy(a)) est = 1;
    end
    eack = iss_en && !est;
    sum = 0;
    foreach (mcnt[r]) sum += mcnt[r];
    chk({tag, ".stall"}, 32'(stall), 32'(est));
    chk({tag, ".ack"},   32'(iss_ack), 32'(eack));
    chk({tag, ".pend"},  32'(pend_cnt), 32'(sum));
    @(posedge clk);
    if (rst) begin
      foreach (mregs[r]) begin mregs[r] = '0; mcnt[r] = 0; end
    end else begin
      dec = wr_en && mcnt[wr_addr] != 0;
      if (wr_en && !(ZR && wr_addr == 0)) mregs[wr_addr] = wr_data;
      if (eack && !(ZR && iss_addr == 0)) mcnt[iss_addr]++;
      if (dec) mcnt[wr_addr]--;
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; rd_use = '0; wr_en = 0; iss_en = 0;
  endtask

  initial begin
    rst = 1; rd_addr = '0; rd_use = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    iss_en = 0; iss_addr = '0;
    foreach (mregs[r]) begin mregs[r] = '0; mcnt[r] = 0; end
    @(posedge clk); #1;

    // reset, reads of 3/5
    rst = 1; rd_addr = {3'd5, 3'd3};
    cyc("rst");
    // write-through of reg 2
    idle(); wr_en = 1; wr_addr = 3'd2; wr_data = 16'h4444; rd_addr = {3'd5, 3'd2};
    cyc("wr_byp");
    idle(); cyc("wr_vis");
    // RAW hazard resolved by WB in the same cycle
    idle(); iss_en = 1; iss_addr = 3'd4; cyc("iss4");
    idle(); rd_use = 2'b01; rd_addr = {3'd0, 3'd4}; cyc("raw_stall");
    wr_en = 1; wr_addr = 3'd4; wr_data = 16'h8002; cyc("raw_res");
    // saturation of reg 6
    idle(); iss_en = 1; iss_addr = 3'd6;
    cyc("sat1"); cyc("sat2"); cyc("sat3");
    wr_en = 1; wr_addr = 3'd6; wr_data = 16'h0600; cyc("sat4");
    wr_en = 0; cyc("sat_ack");
    idle(); wr_en = 1; wr_addr = 3'd6;
    repeat (4) cyc("drain6");
    // simultaneous issue and write to reg 1
    idle(); iss_en = 1; iss_addr = 3'd1; cyc("iss1");
    wr_en = 1; wr_addr = 3'd1; wr_data = 16'h1111; cyc("iss_wr1");
    idle(); rd_addr = {3'd1, 3'd0}; cyc("post1");
    // zero register behaviour (ordinary register when the feature is off)
    idle(); wr_en = 1; wr_addr = 3'd0; wr_data = 16'hFFFD; rd_addr = {3'd0, 3'd0}; cyc("z_wr");
    idle(); iss_en = 1; iss_addr = 3'd0; cyc("z_iss");
    idle(); rd_use = 2'b11; cyc("z_rd");

    for (int k = 0; k < 600; k++) begin
      rst      = ($urandom_range(0, 80) == 0);
      rd_addr  = (NRD*AW)'($urandom);
      rd_use   = NRD'($urandom);
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = AW'($urandom_range(0, 3));
      wr_data  = DW'($urandom);
      iss_en   = ($urandom_range(0, 1) == 1);
      iss_addr = AW'($urandom_range(0, 3));
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
